// File: rtl/display_pkg.sv
// Shared display geometry, sprite position type and scheduler state encoding.
// Optional position clamp helper used when SPRITE_CLAMP_EN is defined.
package display_pkg;
   localparam int H_VISIBLE = 1600;
   localparam int V_VISIBLE = 1200;
   localparam int H_TOTAL   = 2160;
   localparam int V_TOTAL   = 1250;
   localparam int ROW_W     = 11;
   localparam int COL_W     = 12;

   typedef struct packed {
      logic [ROW_W-1:0] row;
      logic [COL_W-1:0] col;
   } sprite_pos_t;

   typedef enum logic {
      ACCEPT = 1'b0,
      COMMIT = 1'b1
   } sched_state_e;

   function automatic sprite_pos_t clamp_pos(input sprite_pos_t p);
      sprite_pos_t q;
      q.row = (p.row > ROW_W'(V_VISIBLE - 1)) ? ROW_W'(V_VISIBLE - 1) : p.row;
      q.col = (p.col > COL_W'(H_VISIBLE - 1)) ? COL_W'(H_VISIBLE - 1) : p.col;
      return q;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant to a valid requester when enabled.
// Grant implies transfer; pointer moves to winner+1 on grant, holds otherwise.
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic         i_clk,
   input  logic         i_rst_l,
   input  logic         i_enable,
   input  logic [N-1:0] i_valid,
   output logic [N-1:0] o_grant
);
   localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

   logic [PTR_W-1:0] r_ptr;
   logic [PTR_W-1:0] w_next_ptr;
   logic [N-1:0]     w_grant;
   logic             w_found;
   int               w_idx;

   always_comb begin
      w_grant    = '0;
      w_next_ptr = r_ptr;
      w_found    = 1'b0;
      w_idx      = 0;
      for (int i = 0; i < N; i++) begin
         w_idx = (int'(r_ptr) + i) % N;
         if (!w_found && i_enable && i_valid[PTR_W'(w_idx)]) begin
            w_found                = 1'b1;
            w_grant[PTR_W'(w_idx)] = 1'b1;
            w_next_ptr             = PTR_W'((w_idx + 1) % N);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_l) begin
         r_ptr <= '0;
      end else if (w_found) begin
         r_ptr <= w_next_ptr;
      end
   end

   assign o_grant = w_grant;
endmodule

// File: rtl/sprite_frame_scheduler.sv
// Shadows sprite position updates and commits dirty ones once per frame at the raster wrap (outputs move 2 cycles after wrap).
// req_ready is held low in the COMMIT cycle; positions clamp to the visible area when SPRITE_CLAMP_EN is defined.
module sprite_frame_scheduler
   import display_pkg::*;
#(
   parameter  int SPRITES    = 1,
   parameter  int REQUESTERS = 2,
   localparam int SID_W      = (SPRITES > 1) ? $clog2(SPRITES) : 1
) (
   input  logic                             clock_162,
   input  logic                             rst_l,
   input  logic [REQUESTERS-1:0]            req_valid,
   output logic [REQUESTERS-1:0]            req_ready,
   input  logic [REQUESTERS-1:0][SID_W-1:0] req_id,
   input  logic [REQUESTERS-1:0][ROW_W-1:0] req_row,
   input  logic [REQUESTERS-1:0][COL_W-1:0] req_col,
   input  logic [ROW_W-1:0]                 scan_row,
   input  logic [COL_W-1:0]                 scan_col,
   output logic [SPRITES-1:0][ROW_W-1:0]    sprite_row,
   output logic [SPRITES-1:0][COL_W-1:0]    sprite_col,
   output logic                             frame_start,
   output logic [15:0]                      frame_count,
   output logic                             commit_pending,
   output logic                             bad_id
);
   sched_state_e                  r_state;
   sprite_pos_t [SPRITES-1:0]     r_shadow;
   logic [SPRITES-1:0]            r_dirty;
   logic [SPRITES-1:0][ROW_W-1:0] r_sprite_row;
   logic [SPRITES-1:0][COL_W-1:0] r_sprite_col;
   logic                          r_frame_start;
   logic [15:0]                   r_frame_count;
   logic                          r_bad_id;

   logic                  w_enable;
   logic                  w_boundary;
   logic [REQUESTERS-1:0] w_grant;
   logic                  w_xfer;
   logic [SID_W-1:0]      w_win_id;
   sprite_pos_t           w_win_pos;
   sprite_pos_t           w_wr_pos;
   logic                  w_id_ok;

   assign w_boundary = (scan_row == '0) && (scan_col == '0);
   // Gating with rst_l keeps req_ready low while reset is held.
   assign w_enable   = (r_state == ACCEPT) && rst_l;

   rr_arbiter #(
      .N(REQUESTERS)
   ) u_arb (
      .i_clk    (clock_162),
      .i_rst_l  (rst_l),
      .i_enable (w_enable),
      .i_valid  (req_valid),
      .o_grant  (w_grant)
   );

   always_comb begin
      w_xfer    = |w_grant;
      w_win_id  = '0;
      w_win_pos = '0;
      for (int r = 0; r < REQUESTERS; r++) begin
         if (w_grant[r]) begin
            w_win_id      = req_id[r];
            w_win_pos.row = req_row[r];
            w_win_pos.col = req_col[r];
         end
      end
   end

`ifdef SPRITE_CLAMP_EN
   assign w_wr_pos = clamp_pos(w_win_pos);
`else
   assign w_wr_pos = w_win_pos;
`endif

   assign w_id_ok = (int'(w_win_id) < SPRITES);

   always_ff @(posedge clock_162) begin
      if (!rst_l) begin
         r_state       <= ACCEPT;
         r_shadow      <= '0;
         r_dirty       <= '0;
         r_sprite_row  <= '0;
         r_sprite_col  <= '0;
         r_frame_start <= 1'b0;
         r_frame_count <= '0;
         r_bad_id      <= 1'b0;
      end else begin
         case (r_state)
            ACCEPT: begin
               if (w_xfer) begin
                  if (w_id_ok) begin
                     r_shadow[w_win_id] <= w_wr_pos;
                     r_dirty[w_win_id]  <= 1'b1;
                  end else begin
                     r_bad_id <= 1'b1;
                  end
               end
               if (w_boundary) begin
                  r_state       <= COMMIT;
                  r_frame_start <= 1'b1;
               end
            end
            COMMIT: begin
               for (int s = 0; s < SPRITES; s++) begin
                  if (r_dirty[s]) begin
                     r_sprite_row[s] <= r_shadow[s].row;
                     r_sprite_col[s] <= r_shadow[s].col;
                  end
               end
               r_dirty       <= '0;
               r_frame_count <= r_frame_count + 16'd1;
               r_frame_start <= 1'b0;
               r_state       <= ACCEPT;
            end
         endcase
      end
   end

   assign req_ready      = w_grant;
   assign sprite_row     = r_sprite_row;
   assign sprite_col     = r_sprite_col;
   assign frame_start    = r_frame_start;
   assign frame_count    = r_frame_count;
   assign commit_pending = |r_dirty;
   assign bad_id         = r_bad_id;
endmodule

// File: tb/tb_sprite_frame_scheduler.sv
// Scoreboard bench for sprite_frame_scheduler with three sprites and two requesters.
module tb_sprite_frame_scheduler;
   localparam int SPRITES    = 3;
   localparam int REQUESTERS = 2;

   logic                clock_162 = 1'b0;
   logic                rst_l;
   logic [1:0]          req_valid;
   logic [1:0]          req_ready;
   logic [1:0][1:0]     req_id;
   logic [1:0][10:0]    req_row;
   logic [1:0][11:0]    req_col;
   logic [10:0]         scan_row;
   logic [11:0]         scan_col;
   logic [2:0][10:0]    sprite_row;
   logic [2:0][11:0]    sprite_col;
   logic                frame_start;
   logic [15:0]         frame_count;
   logic                commit_pending;
   logic                bad_id;

   always #5 clock_162 = ~clock_162;

   sprite_frame_scheduler #(
      .SPRITES    (SPRITES),
      .REQUESTERS (REQUESTERS)
   ) dut (
      .clock_162      (clock_162),
      .rst_l          (rst_l),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_id         (req_id),
      .req_row        (req_row),
      .req_col        (req_col),
      .scan_row       (scan_row),
      .scan_col       (scan_col),
      .sprite_row     (sprite_row),
      .sprite_col     (sprite_col),
      .frame_start    (frame_start),
      .frame_count    (frame_count),
      .commit_pending (commit_pending),
      .bad_id         (bad_id)
   );

   typedef struct packed {
      logic [2:0][10:0] row;
      logic [2:0][11:0] col;
      logic [15:0]      fc;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   logic [2:0][10:0] m_sh_row, m_act_row;
   logic [2:0][11:0] m_sh_col, m_act_col;
   logic [2:0]       m_dirty;
   logic [15:0]      m_fc;
   logic             m_bad;
   int               m_ptr;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock_162);
      #1;
   endtask

   task automatic model_reset();
      m_sh_row = '0; m_sh_col = '0; m_act_row = '0; m_act_col = '0;
      m_dirty = '0; m_fc = '0; m_bad = 1'b0; m_ptr = 0;
      sb_q.delete();
   endtask

   task automatic model_accept(input int id, input logic [10:0] row, input logic [11:0] col);
      logic [10:0] r;
      logic [11:0] c;
      r = row;
      c = col;
`ifdef SPRITE_CLAMP_EN
      if (r > 11'd1199) r = 11'd1199;
      if (c > 12'd1599) c = 12'd1599;
`endif
      if (id < SPRITES) begin
         m_sh_row[id] = r;
         m_sh_col[id] = c;
         m_dirty[id]  = 1'b1;
      end else begin
         m_bad = 1'b1;
      end
   endtask

   task automatic push_commit();
      exp_t e;
      for (int s = 0; s < SPRITES; s++) begin
         if (m_dirty[s]) begin
            m_act_row[s] = m_sh_row[s];
            m_act_col[s] = m_sh_col[s];
         end
      end
      m_dirty = '0;
      m_fc    = m_fc + 16'd1;
      e.row = m_act_row;
      e.col = m_act_col;
      e.fc  = m_fc;
      sb_q.push_back(e);
   endtask

   task automatic write1(input int r, input int id, input logic [10:0] row, input logic [11:0] col);
      req_valid[r] = 1'b1;
      req_id[r]    = 2'(id);
      req_row[r]   = row;
      req_col[r]   = col;
      #1;
      check("ready_single", req_ready, 64'(2'b01 << r));
      tick();
      req_valid[r] = 1'b0;
      model_accept(id, row, col);
      m_ptr = (r + 1) % REQUESTERS;
   endtask

   task automatic enter_commit();
      scan_row = '0;
      scan_col = '0;
      tick();
      scan_row = 11'd5;
      scan_col = 12'd7;
      push_commit();
      #1;
      check("fs_commit", frame_start, 1);
      check("ready_commit", req_ready, 0);
   endtask

   task automatic leave_commit();
      exp_t e;
      tick();
      check("fs_after", frame_start, 0);
      if (sb_q.size() == 0) begin
         check("sb_nonempty", 0, 1);
      end else begin
         e = sb_q.pop_front();
         check("commit_row", sprite_row, e.row);
         check("commit_col", sprite_col, e.col);
         check("commit_fc", frame_count, e.fc);
      end
      check("pending_after", commit_pending, |m_dirty);
   endtask

   task automatic idle(input int n);
      int pulses;
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (frame_start) pulses++;
      end
      check("idle_no_fs", pulses, 0);
      check("idle_row", sprite_row, m_act_row);
   endtask

   task automatic do_reset();
      rst_l = 1'b0;
      tick();
      tick();
      rst_l = 1'b1;
      model_reset();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      req_valid = '0; req_id = '0; req_row = '0; req_col = '0;
      scan_row = 11'd5; scan_col = 12'd7;
      rst_l = 1'b0;
      model_reset();
      tick(); tick(); tick();
      req_valid = 2'b11;
      #1;
      check("rst_ready", req_ready, 0);
      req_valid = '0;
      check("rst_row", sprite_row, 0);
      check("rst_col", sprite_col, 0);
      check("rst_fs", frame_start, 0);
      check("rst_fc", frame_count, 0);
      check("rst_pending", commit_pending, 0);
      check("rst_bad", bad_id, 0);
      rst_l = 1'b1;

      // Empty frames: counter advances, positions stay 0.
      idle(20);
      enter_commit();
      leave_commit();
      idle(20);

      // Single write commits at the next boundary only.
      write1(0, 0, 11'd600, 12'd800);
      check("pending_set", commit_pending, 1);
      idle(5);
      enter_commit();
      check("hold_in_commit", sprite_row, 0);
      leave_commit();
      check("s0_row_const", sprite_row[0], 600);

      // Reset mid-frame discards the pending update.
      write1(1, 1, 11'd100, 12'd200);
      check("pending_set2", commit_pending, 1);
      do_reset();
      check("rst2_pending", commit_pending, 0);
      check("rst2_row", sprite_row, 0);
      check("rst2_fc", frame_count, 0);

      // Contention: both requesters target sprite 0, grants alternate.
      req_valid = 2'b11;
      req_id[0] = 2'd0; req_row[0] = 11'd300; req_col[0] = 12'd400;
      req_id[1] = 2'd0; req_row[1] = 11'd500; req_col[1] = 12'd600;
      for (int k = 0; k < 5; k++) begin
         #1;
         check("rr_grant", req_ready, 64'(2'b01 << m_ptr));
         tick();
         model_accept(0, req_row[m_ptr], req_col[m_ptr]);
         m_ptr = (m_ptr + 1) % REQUESTERS;
      end
      req_valid = '0;
      write1(1, 2, 11'd1000, 12'd1500);
      enter_commit();
      leave_commit();
      check("last_wins_row", sprite_row[0], 300);

      // Request raised during COMMIT waits one cycle and lands next frame.
      enter_commit();
      req_valid[0] = 1'b1; req_id[0] = 2'd1; req_row[0] = 11'd700; req_col[0] = 12'd900;
      #1;
      check("ready_commit_held", req_ready, 0);
      leave_commit();
      check("ready_after_commit", req_ready, 2'b01);
      tick();
      req_valid[0] = 1'b0;
      model_accept(1, 11'd700, 12'd900);
      m_ptr = 1;
      check("pending_held", commit_pending, 1);

      // Transfer in the boundary cycle itself is part of that commit.
      req_valid[1] = 1'b1; req_id[1] = 2'd0; req_row[1] = 11'd50; req_col[1] = 12'd60;
      scan_row = '0; scan_col = '0;
      #1;
      check("ready_boundary", req_ready, 2'b10);
      tick();
      req_valid[1] = 1'b0;
      scan_row = 11'd5; scan_col = 12'd7;
      model_accept(0, 11'd50, 12'd60);
      m_ptr = 0;
      push_commit();
      #1;
      check("fs_boundary", frame_start, 1);
      leave_commit();

      // Out-of-range id: accepted, nothing written, sticky flag.
      write1(0, 3, 11'd111, 12'd222);
      check("bad_set", bad_id, 1);
      check("bad_no_pending", commit_pending, 0);
      enter_commit();
      leave_commit();
      idle(5);
      check("bad_sticky", bad_id, m_bad);
      do_reset();
      check("bad_cleared", bad_id, 0);

      // Oversized coordinates: clamped or stored verbatim depending on build.
      write1(0, 2, 11'd2000, 12'd4000);
      enter_commit();
      leave_commit();
`ifdef SPRITE_CLAMP_EN
      check("big_row", sprite_row[2], 1199);
      check("big_col", sprite_col[2], 1599);
`else
      check("big_row", sprite_row[2], 2000);
      check("big_col", sprite_col[2], 4000);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
